// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and state encoding for the UART transmit arbiter.
// The frame-time default matches tx_uart's baud divider.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Clock cycles per 10-bit 8N1 frame.
    function automatic int unsigned frame_cycles(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz / baud) * 10 + ((clk_hz % baud) * 10) / baud;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? 2 : 1;
    endfunction

    localparam int unsigned DEF_BYTE_CYCLES  = frame_cycles(50_000_000, 9600);
    localparam int unsigned DEF_LOCK_TIMEOUT = 65535;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after 'start', wrapping.
module rr_picker #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   start,
    output logic            found,
    output logic [IW-1:0]   idx
);

    logic [NREQ-1:0] rot;

    always_comb begin
        rot   = NREQ'({req, req} >> start);
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = IW'((32'(start) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one tx_uart between NREQ byte streams.
// Paces send strobes one UART frame apart, since tx_uart has no busy output.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned BYTE_CYCLES  = DEF_BYTE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int unsigned CNT_W        = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic              tx_ready,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [1:0]        owner
);

    localparam int unsigned IW = idx_width(NREQ);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  tcnt;
    logic              lock;
    logic [IW-1:0]     owner_idx;
    // Index with first priority at the next unlocked decision (last grant + 1).
    logic [IW-1:0]     rr_next;

    logic [NREQ-1:0]   cand;
    logic              found;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     pick_inc;
    logic              at_d;

    assign cand     = lock ? (req_valid & (NREQ'(1) << owner_idx)) : req_valid;
    assign at_d     = (state == S_IDLE) || (state == S_HOLD) || ((state == S_WAIT) && (cnt == '0));
    assign pick_inc = (pick == IW'(NREQ - 1)) ? '0 : pick + IW'(1);

    rr_picker #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (cand),
        .start (rr_next),
        .found (found),
        .idx   (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            lock      <= 1'b0;
            owner_idx <= '0;
            rr_next   <= '0;
            tx_ready  <= 1'b0;
            req_ack   <= '0;
            tx_data   <= '0;
        end else begin
            tx_ready <= 1'b0;
            req_ack  <= '0;
            if ((state == S_WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (at_d) begin
                if (found) begin
                    tx_ready  <= 1'b1;
                    req_ack   <= NREQ'(1) << pick;
                    tx_data   <= req_data[{pick, 3'b000} +: 8];
                    owner_idx <= pick;
                    rr_next   <= pick_inc;
                    lock      <= ~req_last[pick];
                    state     <= S_WAIT;
                    cnt       <= CNT_W'(BYTE_CYCLES - 1);
                end else if (lock) begin
                    if (state != S_HOLD) begin
                        state <= S_HOLD;
                        tcnt  <= '0;
                    end else if (tcnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        lock  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + CNT_W'(1);
                    end
                end else begin
                    state <= S_IDLE;
                end
            end
        end
    end

    assign busy  = (state != S_IDLE) || lock;
    assign owner = 2'(owner_idx);

endmodule
